// File: rtl/coreinfo_strings_if.sv
// ZX-UNO register-bus slice seen by the core information block.
// The master side is the bus/decoder and the slave side is the peripheral.
interface coreinfo_strings_if;
  logic [7:0] zxuno_addr;
  logic       zxuno_regrd;
  logic       zxuno_regwr;
  logic       regaddr_changed;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe_n;

  modport master (
    output zxuno_addr, zxuno_regrd, zxuno_regwr, regaddr_changed, din,
    input  dout, oe_n
  );

  modport slave (
    input  zxuno_addr, zxuno_regrd, zxuno_regwr, regaddr_changed, din,
    output dout, oe_n
  );
endinterface

// File: rtl/coreinfo_strings.sv
// Core information register: streams NUM_STR fixed ASCII strings byte by byte
// through ADDR_STR, with a string selector and selector readback on ADDR_SEL.
module coreinfo_strings #(
  parameter logic [7:0] ADDR_STR = 8'hFF,
  parameter logic [7:0] ADDR_SEL = 8'hFE,
  parameter int         NUM_STR  = 4,
  parameter int         STR_LEN  = 16,
  parameter int         END_MODE = 0,
  // String image, byte i at bits [8*i +: 8]; string s starts at byte s*STR_LEN.
  parameter logic [NUM_STR*STR_LEN*8-1:0] ROM_IMAGE = '0
) (
  input  logic             clk,
  input  logic             rst,
  coreinfo_strings_if.slave bus
);

  localparam int SW        = (NUM_STR > 1) ? $clog2(NUM_STR) : 1;
  localparam int IW        = $clog2(STR_LEN);
  localparam int ROM_BYTES = NUM_STR * STR_LEN;

  logic [7:0]    rom [ROM_BYTES];
  logic [SW-1:0] sel;
  logic [IW-1:0] idx;
  logic          reading;
  logic [7:0]    cur_byte;
  logic          terminator;
  logic          str_read;
  logic          sel_addr;

  for (genvar i = 0; i < ROM_BYTES; i++) begin : g_rom
    assign rom[i] = ROM_IMAGE[i*8 +: 8];
  end

  assign sel_addr   = (bus.zxuno_addr == ADDR_SEL);
  assign str_read   = bus.zxuno_regrd && (bus.zxuno_addr == ADDR_STR);
  assign bus.oe_n   = !((str_read || sel_addr) && bus.zxuno_regrd);
  assign cur_byte   = rom[{sel, idx}];
  assign terminator = (cur_byte == 8'h00) || (idx == IW'(STR_LEN - 1));

  // A read strobe may last many cycles, so idx moves only on its falling end;
  // rewind and select writes win over that advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel     <= '0;
      idx     <= '0;
      reading <= 1'b0;
      bus.dout <= 8'h00;
    end else begin
      bus.dout <= sel_addr ? 8'(sel) : cur_byte;
      if (bus.regaddr_changed && (bus.zxuno_addr == ADDR_STR)) begin
        idx     <= '0;
        reading <= 1'b0;
      end else if (bus.zxuno_regwr && sel_addr) begin
        if (int'(bus.din) < NUM_STR) begin
          sel <= bus.din[SW-1:0];
        end
        idx     <= '0;
        reading <= 1'b0;
      end else if (str_read) begin
        reading <= 1'b1;
      end else if (reading) begin
        reading <= 1'b0;
        if (END_MODE == 0) begin
          if (!terminator) begin
            idx <= idx + IW'(1);
          end
        end else begin
          idx <= terminator ? '0 : idx + IW'(1);
        end
      end
    end
  end

endmodule
